avmm_burst_arbiter_2x1: RTL and testbench

Two-master, one-slave Avalon-MM arbiter with burst support. It sits between two Avalon-MM masters (for example, two BFM masters or a CPU plus a DMA) and a single Avalon-MM slave. It grants the shared slave round-robin and holds the grant for the full length of each write burst. Read responses are routed back to the issuing master through an in-order tag FIFO.

---
 rtl/avmm_arb_pkg.sv | 30 +++
 rtl/avmm_rsp_tag_fifo.sv | 50 +++++
 rtl/avmm_burst_arbiter_2x1.sv | 176 +++++++++++++++++
 tb/tb_avmm_burst_arbiter_2x1.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM burst arbiter.
package avmm_arb_pkg;

    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NUM_SYMBOLS = DATA_W / 8;
    localparam int unsigned BURST_W     = 4;
    localparam int unsigned MAX_BURST   = 8;
    localparam int unsigned MAX_PENDING = 4;
    localparam int unsigned PEND_W      = $clog2(MAX_PENDING);

    typedef logic [BURST_W-1:0] burstcount_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } arb_state_t;

    // One outstanding read: issuing master and its beat count.
    typedef struct packed {
        logic        id;
        burstcount_t len;
    } rsp_tag_t;

    // A burstcount of zero is treated as a single beat.
    function automatic burstcount_t norm_burst(input burstcount_t bc);
        return (bc == '0) ? BURST_W'(1) : bc;
    endfunction

endpackage

// File: rtl/avmm_rsp_tag_fifo.sv
// In-order FIFO of read tags used to route read responses back to masters.
module avmm_rsp_tag_fifo
    import avmm_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  rsp_tag_t push_data,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output rsp_tag_t head
);

    localparam int unsigned CNT_W = PEND_W + 1;

    rsp_tag_t          mem [MAX_PENDING];
    logic [PEND_W-1:0] wr_ptr;
    logic [PEND_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PEND_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PEND_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Tag storage; contents are only meaningful while the entry is occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign full  = (count == CNT_W'(MAX_PENDING));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/avmm_burst_arbiter_2x1.sv
// Round-robin 2:1 Avalon-MM arbiter holding grant across write bursts,
// with read responses steered back through an in-order tag FIFO.
module avmm_burst_arbiter_2x1
    import avmm_arb_pkg::*;
(
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [ADDR_W-1:0]      m0_address,
    input  logic                   m0_read,
    input  logic                   m0_write,
    input  logic [DATA_W-1:0]      m0_writedata,
    input  logic [NUM_SYMBOLS-1:0] m0_byteenable,
    input  logic [BURST_W-1:0]     m0_burstcount,
    output logic                   m0_waitrequest,
    output logic [DATA_W-1:0]      m0_readdata,
    output logic                   m0_readdatavalid,
    input  logic [ADDR_W-1:0]      m1_address,
    input  logic                   m1_read,
    input  logic                   m1_write,
    input  logic [DATA_W-1:0]      m1_writedata,
    input  logic [NUM_SYMBOLS-1:0] m1_byteenable,
    input  logic [BURST_W-1:0]     m1_burstcount,
    output logic                   m1_waitrequest,
    output logic [DATA_W-1:0]      m1_readdata,
    output logic                   m1_readdatavalid,
    output logic [ADDR_W-1:0]      slv_address,
    output logic                   slv_read,
    output logic                   slv_write,
    output logic [DATA_W-1:0]      slv_writedata,
    output logic [NUM_SYMBOLS-1:0] slv_byteenable,
    output logic [BURST_W-1:0]     slv_burstcount,
    input  logic                   slv_waitrequest,
    input  logic [DATA_W-1:0]      slv_readdata,
    input  logic                   slv_readdatavalid,
    output logic                   err_orphan_rsp
);

    arb_state_t  state, state_nxt;
    logic        ptr, ptr_nxt;
    logic        burst_id, burst_id_nxt;
    burstcount_t beat_cnt, beat_cnt_nxt;
    burstcount_t rsp_cnt;

    logic        fifo_full, fifo_empty;
    rsp_tag_t    fifo_head;
    rsp_tag_t    push_tag;

    logic        req0, req1;
    logic        gnt_vld, gnt_id;
    logic        sel_read, sel_write;
    burstcount_t sel_bc;
    logic        rd_acc, wr_acc;
    logic        rsp_beat, rsp_pop;

    // A read only counts as a request while there is room to track it.
    assign req0 = m0_write | (m0_read & ~fifo_full);
    assign req1 = m1_write | (m1_read & ~fifo_full);

    // Grant selection: locked to the burst owner, else round-robin among requesters.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state == WR_BURST) begin
            gnt_vld = 1'b1;
            gnt_id  = burst_id;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt_id  = ptr;
        end else if (req0 || req1) begin
            gnt_vld = 1'b1;
            gnt_id  = req1;
        end
    end

    // Command mux toward the slave; write wins when a master raises both.
    always_comb begin
        sel_write      = gnt_id ? m1_write : m0_write;
        sel_read       = (gnt_id ? m1_read : m0_read) & ~sel_write;
        sel_bc         = norm_burst(gnt_id ? m1_burstcount : m0_burstcount);
        slv_address    = gnt_id ? m1_address : m0_address;
        slv_writedata  = gnt_id ? m1_writedata : m0_writedata;
        slv_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
        slv_burstcount = sel_bc;
        slv_write      = reset_reset_n & gnt_vld & sel_write;
        slv_read       = reset_reset_n & gnt_vld & (state == IDLE) & sel_read & ~fifo_full;
        m0_waitrequest = ~reset_reset_n | ~(gnt_vld & ~gnt_id) | slv_waitrequest;
        m1_waitrequest = ~reset_reset_n | ~(gnt_vld & gnt_id) | slv_waitrequest;
    end

    assign rd_acc = slv_read & ~slv_waitrequest;
    assign wr_acc = slv_write & ~slv_waitrequest;

    // Next-state logic for grant state, priority pointer and burst beat count.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        burst_id_nxt = burst_id;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (rd_acc) begin
                    ptr_nxt = ~gnt_id;
                end else if (wr_acc) begin
                    if (sel_bc > BURST_W'(1)) begin
                        state_nxt    = WR_BURST;
                        burst_id_nxt = gnt_id;
                        beat_cnt_nxt = sel_bc - BURST_W'(1);
                    end else begin
                        ptr_nxt = ~gnt_id;
                    end
                end
            end
            WR_BURST: begin
                if (wr_acc) begin
                    if (beat_cnt == BURST_W'(1)) begin
                        state_nxt    = IDLE;
                        ptr_nxt      = ~burst_id;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt - BURST_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            burst_id <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            burst_id <= burst_id_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign push_tag = '{id: gnt_id, len: sel_bc};

    avmm_rsp_tag_fifo u_tag_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (rd_acc),
        .push_data (push_tag),
        .pop       (rsp_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Response steering: data broadcast, valid only to the head tag's master.
    assign rsp_beat         = slv_readdatavalid & ~fifo_empty;
    assign rsp_pop          = rsp_beat & ((rsp_cnt + BURST_W'(1)) == fifo_head.len);
    assign m0_readdata      = slv_readdata;
    assign m1_readdata      = slv_readdata;
    assign m0_readdatavalid = reset_reset_n & rsp_beat & ~fifo_head.id;
    assign m1_readdatavalid = reset_reset_n & rsp_beat & fifo_head.id;

    // Response beat counter and sticky orphan-response flag.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rsp_cnt        <= '0;
            err_orphan_rsp <= 1'b0;
        end else begin
            if (rsp_pop)       rsp_cnt <= '0;
            else if (rsp_beat) rsp_cnt <= rsp_cnt + BURST_W'(1);
            if (slv_readdatavalid && fifo_empty) err_orphan_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avmm_burst_arbiter_2x1.sv
// Directed table-driven bench for avmm_burst_arbiter_2x1.
module tb_avmm_burst_arbiter_2x1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [3:0]  m0_burstcount, m1_burstcount;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] slv_address;
    logic        slv_read, slv_write;
    logic [31:0] slv_writedata;
    logic [3:0]  slv_byteenable;
    logic [3:0]  slv_burstcount;
    logic        slv_waitrequest;
    logic [31:0] slv_readdata;
    logic        slv_readdatavalid;
    logic        err_orphan_rsp;

    int checks = 0;
    int errors = 0;

    assign m0_writedata  = 32'hA000_0000 | 32'(m0_address);
    assign m1_writedata  = 32'hB000_0000 | 32'(m1_address);
    assign m0_byteenable = 4'hF;
    assign m1_byteenable = 4'h3;

    always #5 clk = ~clk;

    avmm_burst_arbiter_2x1 dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .m0_address        (m0_address),
        .m0_read           (m0_read),
        .m0_write          (m0_write),
        .m0_writedata      (m0_writedata),
        .m0_byteenable     (m0_byteenable),
        .m0_burstcount     (m0_burstcount),
        .m0_waitrequest    (m0_waitrequest),
        .m0_readdata       (m0_readdata),
        .m0_readdatavalid  (m0_readdatavalid),
        .m1_address        (m1_address),
        .m1_read           (m1_read),
        .m1_write          (m1_write),
        .m1_writedata      (m1_writedata),
        .m1_byteenable     (m1_byteenable),
        .m1_burstcount     (m1_burstcount),
        .m1_waitrequest    (m1_waitrequest),
        .m1_readdata       (m1_readdata),
        .m1_readdatavalid  (m1_readdatavalid),
        .slv_address       (slv_address),
        .slv_read          (slv_read),
        .slv_write         (slv_write),
        .slv_writedata     (slv_writedata),
        .slv_byteenable    (slv_byteenable),
        .slv_burstcount    (slv_burstcount),
        .slv_waitrequest   (slv_waitrequest),
        .slv_readdata      (slv_readdata),
        .slv_readdatavalid (slv_readdatavalid),
        .err_orphan_rsp    (err_orphan_rsp)
    );

    typedef struct {
        logic        m0_rd, m0_wr;
        logic [11:0] m0_addr;
        logic [3:0]  m0_bc;
        logic        m1_rd, m1_wr;
        logic [11:0] m1_addr;
        logic [3:0]  m1_bc;
        logic        s_wait, s_rdv;
        logic [31:0] s_rdata;
        logic        e_rd, e_wr, e_gnt;
        logic [11:0] e_addr;
        logic [3:0]  e_bc;
        logic        e_w0, e_w1, e_v0, e_v1, e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(
        input logic m0rd, input logic m0wr, input logic [11:0] m0a, input logic [3:0] m0bc,
        input logic m1rd, input logic m1wr, input logic [11:0] m1a, input logic [3:0] m1bc,
        input logic sw, input logic srdv, input logic [31:0] srdata,
        input logic erd, input logic ewr, input logic egnt, input logic [11:0] ea, input logic [3:0] ebc,
        input logic ew0, input logic ew1, input logic ev0, input logic ev1, input logic eerr);
        vec_t v;
        v.m0_rd = m0rd; v.m0_wr = m0wr; v.m0_addr = m0a; v.m0_bc = m0bc;
        v.m1_rd = m1rd; v.m1_wr = m1wr; v.m1_addr = m1a; v.m1_bc = m1bc;
        v.s_wait = sw; v.s_rdv = srdv; v.s_rdata = srdata;
        v.e_rd = erd; v.e_wr = ewr; v.e_gnt = egnt; v.e_addr = ea; v.e_bc = ebc;
        v.e_w0 = ew0; v.e_w1 = ew1; v.e_v0 = ev0; v.e_v1 = ev1; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_burstcount = 4'd1;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_burstcount = 4'd1;
        slv_waitrequest = 1'b0; slv_readdatavalid = 1'b0; slv_readdata = '0;
    endtask

    task automatic drive(input vec_t v);
        m0_read = v.m0_rd; m0_write = v.m0_wr; m0_address = v.m0_addr; m0_burstcount = v.m0_bc;
        m1_read = v.m1_rd; m1_write = v.m1_wr; m1_address = v.m1_addr; m1_burstcount = v.m1_bc;
        slv_waitrequest = v.s_wait; slv_readdatavalid = v.s_rdv; slv_readdata = v.s_rdata;
    endtask

    task automatic compare(input vec_t v, input int i);
        logic [31:0] exp_wd;
        exp_wd = (v.e_gnt ? 32'hB000_0000 : 32'hA000_0000) | 32'(v.e_addr);
        chk("slv_read", i, 32'(slv_read), 32'(v.e_rd));
        chk("slv_write", i, 32'(slv_write), 32'(v.e_wr));
        if (v.e_rd || v.e_wr) begin
            chk("slv_address", i, 32'(slv_address), 32'(v.e_addr));
            chk("slv_burstcount", i, 32'(slv_burstcount), 32'(v.e_bc));
        end
        if (v.e_wr) begin
            chk("slv_writedata", i, slv_writedata, exp_wd);
            chk("slv_byteenable", i, 32'(slv_byteenable), v.e_gnt ? 32'h3 : 32'hF);
        end
        chk("m0_waitrequest", i, 32'(m0_waitrequest), 32'(v.e_w0));
        chk("m1_waitrequest", i, 32'(m1_waitrequest), 32'(v.e_w1));
        chk("m0_readdatavalid", i, 32'(m0_readdatavalid), 32'(v.e_v0));
        chk("m1_readdatavalid", i, 32'(m1_readdatavalid), 32'(v.e_v1));
        chk("err_orphan_rsp", i, 32'(err_orphan_rsp), 32'(v.e_err));
        if (v.s_rdv) begin
            chk("m0_readdata", i, m0_readdata, v.s_rdata);
            chk("m1_readdata", i, m1_readdata, v.s_rdata);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #1 rst_n = 1'b0;
        // Outputs held in reset even with a master requesting.
        m0_write = 1'b1; m0_address = 12'h010;
        #2;
        chk("rst_slv_write", 0, 32'(slv_write), 32'd0);
        chk("rst_slv_read", 0, 32'(slv_read), 32'd0);
        chk("rst_m0_wait", 0, 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 0, 32'(m1_waitrequest), 32'd1);
        chk("rst_rdv", 0, 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        chk("rst_err", 0, 32'(err_orphan_rsp), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        //        m0: rd wr addr   bc    m1: rd wr addr   bc    sw rdv rdata          e: rd wr g addr   bc   w0 w1 v0 v1 err
        tbl.push_back(row(0,0,12'h000,4'd1, 0,0,12'h000,4'd1, 0,0,32'h0,           0,0,0,12'h000,4'd1, 1,1,0,0,0));
        tbl.push_back(row(0,1,12'h010,4'd1, 0,0,12'h000,4'd1, 0,0,32'h0,           0,1,0,12'h010,4'd1, 0,1,0,0,0));
        tbl.push_back(row(0,1,12'h020,4'd1, 0,1,12'h024,4'd1, 0,0,32'h0,           0,1,1,12'h024,4'd1, 1,0,0,0,0));
        tbl.push_back(row(0,1,12'h020,4'd1, 0,1,12'h024,4'd1, 0,0,32'h0,           0,1,0,12'h020,4'd1, 0,1,0,0,0));
        tbl.push_back(row(0,1,12'h020,4'd1, 0,1,12'h024,4'd1, 1,0,32'h0,           0,1,1,12'h024,4'd1, 1,1,0,0,0));
        tbl.push_back(row(0,1,12'h020,4'd1, 0,1,12'h024,4'd1, 1,0,32'h0,           0,1,1,12'h024,4'd1, 1,1,0,0,0));
        tbl.push_back(row(0,1,12'h020,4'd1, 0,1,12'h024,4'd1, 0,0,32'h0,           0,1,1,12'h024,4'd1, 1,0,0,0,0));
        tbl.push_back(row(0,1,12'h020,4'd1, 0,1,12'h024,4'd1, 0,0,32'h0,           0,1,0,12'h020,4'd1, 0,1,0,0,0));
        // m1 burst of 8 with an m0 read waiting; one idle beat and one stalled beat inside
        tbl.push_back(row(1,0,12'h200,4'd4, 0,1,12'h100,4'd8, 0,0,32'h0,           0,1,1,12'h100,4'd8, 1,0,0,0,0));
        tbl.push_back(row(1,0,12'h200,4'd4, 0,1,12'h100,4'd8, 0,0,32'h0,           0,1,1,12'h100,4'd8, 1,0,0,0,0));
        tbl.push_back(row(1,0,12'h200,4'd4, 0,0,12'h100,4'd8, 0,0,32'h0,           0,0,1,12'h100,4'd8, 1,0,0,0,0));
        tbl.push_back(row(1,0,12'h200,4'd4, 0,1,12'h100,4'd8, 0,0,32'h0,           0,1,1,12'h100,4'd8, 1,0,0,0,0));
        tbl.push_back(row(1,0,12'h200,4'd4, 0,1,12'h100,4'd8, 1,0,32'h0,           0,1,1,12'h100,4'd8, 1,1,0,0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(row(1,0,12'h200,4'd4, 0,1,12'h100,4'd8, 0,0,32'h0,       0,1,1,12'h100,4'd8, 1,0,0,0,0));
        // reads: m0 len 4, m1 len 2, then six response beats
        tbl.push_back(row(1,0,12'h200,4'd4, 0,0,12'h000,4'd1, 0,0,32'h0,           1,0,0,12'h200,4'd4, 0,1,0,0,0));
        tbl.push_back(row(0,0,12'h000,4'd1, 1,0,12'h300,4'd2, 0,0,32'h0,           1,0,1,12'h300,4'd2, 1,0,0,0,0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(row(0,0,12'h000,4'd1, 0,0,12'h000,4'd1, 0,1,32'h1111_0000 + k, 0,0,0,12'h000,4'd1, 1,1,1,0,0));
        for (int k = 1; k <= 2; k++)
            tbl.push_back(row(0,0,12'h000,4'd1, 0,0,12'h000,4'd1, 0,1,32'h2222_0000 + k, 0,0,0,12'h000,4'd1, 1,1,0,1,0));
        // read+write together is a write; burstcount 0 is a single beat
        tbl.push_back(row(1,1,12'h040,4'd1, 0,0,12'h000,4'd1, 0,0,32'h0,           0,1,0,12'h040,4'd1, 0,1,0,0,0));
        tbl.push_back(row(0,0,12'h000,4'd1, 0,1,12'h044,4'd0, 0,0,32'h0,           0,1,1,12'h044,4'd1, 1,0,0,0,0));
        tbl.push_back(row(0,1,12'h048,4'd1, 0,0,12'h000,4'd1, 0,0,32'h0,           0,1,0,12'h048,4'd1, 0,1,0,0,0));
        // orphan response
        tbl.push_back(row(0,0,12'h000,4'd1, 0,0,12'h000,4'd1, 0,1,32'hDEAD_0000,   0,0,0,12'h000,4'd1, 1,1,0,0,0));
        tbl.push_back(row(0,0,12'h000,4'd1, 0,0,12'h000,4'd1, 0,0,32'h0,           0,0,0,12'h000,4'd1, 1,1,0,0,1));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #2;
            compare(tbl[i], i);
        end

        // Reset during an m0 burst of 8, after three beats.
        @(negedge clk);
        idle_inputs();
        m0_write = 1'b1; m0_address = 12'h100; m0_burstcount = 4'd8;
        #2 chk("mid_burst_beat", 0, 32'(slv_write), 32'd1);
        for (int b = 1; b < 3; b++) begin
            @(negedge clk);
            #2 chk("mid_burst_beat", b, 32'(slv_write), 32'd1);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_slv_write", 0, 32'(slv_write), 32'd0);
        chk("arst_m0_wait", 0, 32'(m0_waitrequest), 32'd1);
        chk("arst_m1_wait", 0, 32'(m1_waitrequest), 32'd1);
        chk("arst_err", 0, 32'(err_orphan_rsp), 32'd0);
        @(posedge clk);
        #1 chk("arst_slv_write", 1, 32'(slv_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        m1_write = 1'b1; m1_address = 12'h050; m1_burstcount = 4'd1;
        #2;
        chk("post_rst_write", 0, 32'(slv_write), 32'd1);
        chk("post_rst_addr", 0, 32'(slv_address), 32'h050);
        chk("post_rst_m1_wait", 0, 32'(m1_waitrequest), 32'd0);
        chk("post_rst_m0_wait", 0, 32'(m0_waitrequest), 32'd1);

        // Fill the tag FIFO with four reads, then a fifth read must stall.
        @(negedge clk);
        idle_inputs();
        m0_read = 1'b1; m0_burstcount = 4'd1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            m0_address = 12'h400 + 12'(4 * k);
            #2 chk("fill_read", k, 32'(slv_read), 32'd1);
        end
        @(negedge clk);
        m0_address = 12'h410;
        m1_write = 1'b1; m1_address = 12'h060;
        #2;
        chk("full_read_stall", 0, 32'(slv_read), 32'd0);
        chk("full_m0_wait", 0, 32'(m0_waitrequest), 32'd1);
        chk("full_write_gnt", 0, 32'(slv_write), 32'd1);
        chk("full_write_addr", 0, 32'(slv_address), 32'h060);
        chk("full_m1_wait", 0, 32'(m1_waitrequest), 32'd0);
        @(negedge clk);
        m1_write = 1'b0;
        #2;
        chk("full_read_stall", 1, 32'(slv_read), 32'd0);
        chk("full_m0_wait", 1, 32'(m0_waitrequest), 32'd1);
        @(negedge clk);
        slv_readdatavalid = 1'b1; slv_readdata = 32'h5555_0001;
        #2;
        chk("full_rsp_rdv", 0, 32'(m0_readdatavalid), 32'd1);
        chk("full_read_stall", 2, 32'(slv_read), 32'd0);
        @(negedge clk);
        slv_readdatavalid = 1'b0;
        #2;
        chk("fifth_read", 0, 32'(slv_read), 32'd1);
        chk("fifth_addr", 0, 32'(slv_address), 32'h410);
        chk("fifth_m0_wait", 0, 32'(m0_waitrequest), 32'd0);
        @(negedge clk);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
